// File: rtl/mem2wb_master.sv
// CPU native memory port (valid/ready, byte strobes) to Wishbone classic master bridge.
// Define MEM2WB_TIMEOUT_EN to build in the ack watchdog and its sticky timeout_o flag.
module mem2wb_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Fetch flag and byte offset do not influence the bus cycle.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, mem_instr, mem_addr[1:0]};

`ifdef MEM2WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    assign cnt_next = cnt + CW'(1);
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            wb_adr_o  <= 32'h0;
            wb_dat_o  <= 32'h0;
            wb_sel_o  <= 4'h0;
            wb_we_o   <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
`ifdef MEM2WB_TIMEOUT_EN
            cnt       <= '0;
            timeout_o <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (mem_valid) begin
                        wb_adr_o <= {mem_addr[31:2], 2'b00};
                        wb_dat_o <= mem_wdata;
                        wb_we_o  <= |mem_wstrb;
                        wb_sel_o <= (|mem_wstrb) ? mem_wstrb : 4'hF;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= BUS;
`ifdef MEM2WB_TIMEOUT_EN
                        cnt      <= '0;
`endif
                    end
                end
                // Dropping stb on the ack edge keeps "stb & !ack" slaves to a single ack.
                BUS: begin
                    if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        mem_ready <= 1'b1;
                        mem_rdata <= wb_we_o ? 32'h0 : wb_dat_i;
                        state     <= DONE;
                    end
`ifdef MEM2WB_TIMEOUT_EN
                    else if (cnt_next == CW'(TIMEOUT)) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        mem_ready <= 1'b1;
                        mem_rdata <= 32'hFFFF_FFFF;
                        timeout_o <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt_next;
                    end
`endif
                end
                // The CPU still holds mem_valid on this edge, so it must not start a cycle.
                DONE: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem2wb_master.sv
// Directed self-checking bench for mem2wb_master with a behavioural Wishbone RAM slave.
module tb_mem2wb_master;

    logic        wb_clk_i;
    logic        wb_rst_ni;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    mem2wb_master #(.TIMEOUT(8)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .timeout_o (timeout_o)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    // RAM slave: registered ack after ws extra wait cycles; reset reloads 0x40 = 32'h1234_5678.
    logic [31:0] ram [0:255];
    int ws = 0;
    int wcnt;
    int ack_count = 0;
    int cyc_starts = 0;
    logic cyc_d = 1'b0;

    always @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_i <= 1'b0;
            wb_dat_i <= 32'h0;
            wcnt     <= 0;
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[16] <= 32'h1234_5678;
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (wcnt >= ws) begin
                wb_ack_i  <= 1'b1;
                wcnt      <= 0;
                wb_dat_i  <= ram[wb_adr_o[9:2]];
                ack_count <= ack_count + 1;
                if (wb_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (wb_sel_o[b]) ram[wb_adr_o[9:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wb_ack_i <= 1'b0;
            wcnt     <= 0;
        end
    end

    always @(posedge wb_clk_i) begin
        cyc_d <= wb_cyc_o;
        if (wb_cyc_o && !cyc_d) cyc_starts <= cyc_starts + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] hung");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic [31:0] b_adr;
    logic [31:0] b_dat;
    logic [3:0]  b_sel;
    logic        b_we;
    logic        b_cyc;
    logic        ready_after;

    // One CPU request; lat is edges after the sampling edge until mem_ready, -1 if none.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = st;
        mem_valid = 1'b1;
        @(posedge wb_clk_i); #1;
        b_adr = wb_adr_o;
        b_dat = wb_dat_o;
        b_sel = wb_sel_o;
        b_we  = wb_we_o;
        b_cyc = wb_cyc_o & wb_stb_o;
        lat   = -1;
        rd    = 32'hDEAD_0000;
        for (int k = 1; k <= 40; k++) begin
            @(posedge wb_clk_i); #1;
            if (mem_ready) begin
                lat = k;
                rd  = mem_rdata;
                break;
            end
        end
        @(posedge wb_clk_i); #1;
        ready_after = mem_ready;
        mem_valid   = 1'b0;
    endtask

    int acks0;
    int starts0;
    int rdy_n;
    int rdy_at [0:3];
    logic stable;

    initial begin
        wb_rst_ni = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        #12;
        check("rst_outputs", {mem_ready, wb_we_o, wb_cyc_o, wb_stb_o, timeout_o, wb_sel_o}, 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        wb_rst_ni = 1'b1;
        @(posedge wb_clk_i); #1;

        // Zero-wait read of 0x40
        acks0 = ack_count;
        mem_instr = 1'b1;
        do_req(32'h40, 32'h0, 4'h0);
        mem_instr = 1'b0;
        check("rd_cyc", {31'h0, b_cyc}, 32'h1);
        check("rd_adr", b_adr, 32'h40);
        check("rd_sel", {28'h0, b_sel}, 32'hF);
        check("rd_we", {31'h0, b_we}, 32'h0);
        check("rd_latency", lat, 2);
        check("rd_data", rd, 32'h1234_5678);
        check("rd_pulse_1cyc", {31'h0, ready_after}, 32'h0);
        check("rd_one_ack", ack_count - acks0, 1);

        // Partial write, then read back the word
        do_req(32'h44, 32'hAABB_CCDD, 4'b0101);
        check("wr_we", {31'h0, b_we}, 32'h1);
        check("wr_sel", {28'h0, b_sel}, 32'h5);
        check("wr_adr", b_adr, 32'h44);
        check("wr_dat", b_dat, 32'hAABB_CCDD);
        check("wr_latency", lat, 2);
        check("wr_rdata_zero", rd, 32'h0);
        do_req(32'h47, 32'h0, 4'h0);
        check("rb_adr_align", b_adr, 32'h44);
        check("rb_data", rd, 32'h00BB_00DD);

        // Back-to-back with mem_valid held
        acks0   = ack_count;
        starts0 = cyc_starts;
        rdy_n   = 0;
        mem_addr  = 32'h40;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge wb_clk_i); #1;
            if (mem_ready) begin
                if (rdy_n < 4) rdy_at[rdy_n] = i;
                rdy_n++;
            end
        end
        mem_valid = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("b2b_ready_count", rdy_n, 3);
        check("b2b_first", rdy_at[0], 2);
        check("b2b_interval1", rdy_at[1] - rdy_at[0], 4);
        check("b2b_interval2", rdy_at[2] - rdy_at[1], 4);
        check("b2b_cycles", cyc_starts - starts0, 3);
        check("b2b_acks", ack_count - acks0, 3);

        // Five slave wait states; CPU inputs change mid-BUS and must be ignored
        ws = 5;
        mem_addr  = 32'h40;
        mem_wdata = 32'h1122_3344;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        @(posedge wb_clk_i); #1;
        mem_addr  = 32'h80;
        mem_wdata = 32'h5566_7788;
        mem_wstrb = 4'h3;
        stable = (wb_adr_o == 32'h40) && (wb_dat_o == 32'h1122_3344) && (wb_sel_o == 4'hF);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge wb_clk_i); #1;
            if (mem_ready) begin
                lat = k;
                rd  = mem_rdata;
                break;
            end
            if (!((wb_adr_o == 32'h40) && (wb_dat_o == 32'h1122_3344) &&
                  (wb_sel_o == 4'hF) && wb_cyc_o && !wb_we_o)) stable = 1'b0;
        end
        @(posedge wb_clk_i); #1;
        mem_valid = 1'b0;
        ws = 0;
        check("ws5_stable", {31'h0, stable}, 32'h1);
        check("ws5_latency", lat, 7);
        check("ws5_data", rd, 32'h1234_5678);

        // Asynchronous reset in the middle of BUS
        ws = 10;
        mem_addr  = 32'h40;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        @(posedge wb_clk_i); #1;
        @(posedge wb_clk_i); #1;
        check("arst_in_bus", {31'h0, wb_cyc_o}, 32'h1);
        acks0 = ack_count;
        wb_rst_ni = 1'b0;
        #1;
        check("arst_cyc_stb_rdy", {29'h0, wb_cyc_o, wb_stb_o, mem_ready}, 32'h0);
        mem_valid = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        ws = 0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("arst_no_late_ack", ack_count - acks0, 0);
        check("arst_idle", {31'h0, wb_cyc_o}, 32'h0);
        do_req(32'h40, 32'h0, 4'h0);
        check("arst_fresh_lat", lat, 2);
        check("arst_fresh_data", rd, 32'h1234_5678);

`ifdef MEM2WB_TIMEOUT_EN
        // Ack on the eighth BUS cycle coincides with expiry: ack wins
        ws = 6;
        do_req(32'h40, 32'h0, 4'h0);
        check("to_edge_lat", lat, 8);
        check("to_edge_data", rd, 32'h1234_5678);
        check("to_edge_flag", {31'h0, timeout_o}, 32'h0);
        // Slave never acks
        ws = 1000;
        do_req(32'h40, 32'h0, 4'h0);
        check("to_lat", lat, 8);
        check("to_data", rd, 32'hFFFF_FFFF);
        check("to_cyc_low", {31'h0, wb_cyc_o}, 32'h0);
        check("to_flag", {31'h0, timeout_o}, 32'h1);
        ws = 0;
        do_req(32'h40, 32'h0, 4'h0);
        check("to_sticky", {31'h0, timeout_o}, 32'h1);
        check("to_after_data", rd, 32'h1234_5678);
`else
        check("no_wdog_flag", {31'h0, timeout_o}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem2wb_master.md
# mem2wb_master

Bridge between the CPU native memory port (valid/ready, byte strobes) and a Wishbone classic master port. Sits directly upstream of the on-chip Wishbone RAM and the console/test-status addresses that RAM decodes. Converts one CPU request at a time into exactly one Wishbone cycle and returns read data to the CPU. An optional watchdog terminates cycles that are never acknowledged.

## Interface

Parameters:
- `TIMEOUT`, default 255: cycles the bridge waits for `wb_ack_i` before aborting. Used only when the watchdog is compiled in. Legal range 1..65535.

Ports:
- `wb_clk_i`  in  1  single clock, rising edge.
- `wb_rst_ni`  in  1  reset, asynchronous, active-low.
- `mem_valid`  in  1  CPU request valid; held until `mem_ready`.
- `mem_instr`  in  1  request is an instruction fetch; informational, no effect on behaviour.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes; 0 = read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1.
- `wb_adr_o`  out  32  Wishbone address.
- `wb_dat_o`  out  32  Wishbone write data.
- `wb_sel_o`  out  4  byte selects.
- `wb_we_o`  out  1  write enable.
- `wb_cyc_o`  out  1  cycle.
- `wb_stb_o`  out  1  strobe.
- `wb_dat_i`  in  32  Wishbone read data.
- `wb_ack_i`  in  1  acknowledge.
- `timeout_o`  out  1  sticky abort flag; watchdog builds only.

## Operation

- All outputs are registered.
- Reset value of every output is 0. Reset puts the FSM in IDLE and clears the counter and `timeout_o`.
- FSM states:
  - IDLE: `mem_valid`=1 -> BUS. On that edge, latch the request into the Wishbone outputs and assert `cyc`/`stb`.
  - BUS: `wb_ack_i`=1 -> DONE. On that edge, deassert `cyc`/`stb`/`we`, set `mem_ready`=1, and load `mem_rdata` with `wb_dat_i` for reads or 0 for writes.
  - DONE: `mem_ready`=0 -> IDLE unconditionally. `mem_valid` is ignored in DONE, because the CPU still holds it on this edge.
- Request mapping:
  - `wb_adr_o` = {`mem_addr`[31:2], 2'b00}.
  - `wb_we_o` = |`mem_wstrb`.
  - `wb_sel_o` = `mem_wstrb` for writes, 4'hF for reads.
  - `wb_dat_o` = `mem_wdata`.
- Wishbone outputs are held stable for the whole of BUS. The CPU-side inputs are not re-sampled during BUS.
- `wb_ack_i` outside BUS is ignored.
- At most one outstanding cycle. No pipelining and no `wb_err`/`wb_rty`.
- Asynchronous reset in BUS drops `cyc`/`stb` immediately, without waiting for a clock edge. A slave ack arriving later is ignored.

## Timing

- Zero-wait-state slave, where ack is registered one cycle after `stb`:
  - request sampled at edge N;
  - `stb` high after N;
  - ack high after N+1;
  - ack sampled at N+2;
  - `mem_ready` high for the cycle after N+2;
  - IDLE after N+3.
- The earliest next request is sampled at edge N+4. Minimum issue interval is 4 cycles.
- Slave wait states add 1:1 to latency.
- `stb` is deasserted on the same edge that samples ack. This guarantees that a slave generating ack as "valid & !ack" sees only one ack per request.

## Configuration

- `MEM2WB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter reaches `TIMEOUT`, the bridge takes the DONE path with `mem_rdata`=32'hFFFF_FFFF and sets `timeout_o`=1. `timeout_o` stays set until reset.
  - If ack and expiry occur on the same edge, ack wins: normal data is returned and no flag is set.
- `MEM2WB_TIMEOUT_EN` undefined:
  - No counter. BUS waits indefinitely.
  - `timeout_o` is tied to 0.

## Test plan

- Read with a zero-wait RAM model holding 32'h1234_5678 at 0x40: request at edge 0 gives `mem_ready` in cycle 3, `mem_rdata`=32'h1234_5678, `wb_sel_o`=4'hF, and exactly one ack.
- Write `mem_addr`=0x44, `mem_wdata`=32'hAABB_CCDD, `mem_wstrb`=4'b0101: Wishbone shows `we`=1, `sel`=4'b0101, `adr`=0x44. A follow-up read returns 32'h00BB_00DD over a zeroed word.
- Back-to-back requests with `mem_valid` held continuously: exactly one Wishbone cycle per `mem_ready` pulse, no duplicate cycle during DONE, and a 4-cycle issue interval.
- Slave inserting 5 wait states: `wb_adr_o`/`wb_dat_o`/`wb_sel_o` are stable throughout and `mem_ready` arrives 5 cycles later than in the zero-wait case.
- With `MEM2WB_TIMEOUT_EN` and `TIMEOUT`=8, a slave that never acks: `cyc` drops after 8 BUS cycles, `mem_rdata`=32'hFFFF_FFFF, `timeout_o`=1. With ack on cycle 8 exactly, normal data is returned and `timeout_o`=0.
- Assert `wb_rst_ni` low mid-BUS: `cyc`/`stb`/`mem_ready` go to 0 before the next edge. After release, a fresh read completes normally.
